// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: two-master AHB arbiter, M0 priority with a burst-count fairness cap for M1.
module ahb_master_arbiter #(
  parameter int MAX_M0_BURSTS = 4
) (
  input  logic        HCLK,
  input  logic        HRESET_N,
  input  logic [31:0] M0_HADDR,
  input  logic [2:0]  M0_HBURST,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [2:0]  M1_HBURST,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [1:0]  GRANT
);
  localparam int CW = $clog2(MAX_M0_BURSTS + 1);
  typedef enum logic [1:0] {NONE, OWN0, OWN1} state_t;
  state_t state, state_nx, pick;
  logic [1:0] dp;
  logic [4:0] beat, len;
  logic incr;
  logic [CW-1:0] m0_cnt, m0_cnt_nx;
  logic m0_req, m1_req, acc, nonseq_acc, seq_acc, idle_acc, fixed_end, burst_end, rearb;
  assign m0_req = M0_HTRANS != 2'd0;
  assign m1_req = M1_HTRANS != 2'd0;
  assign GRANT  = {state == OWN1, state == OWN0};
  assign HADDR  = state == OWN0 ? M0_HADDR  : state == OWN1 ? M1_HADDR  : '0;
  assign HBURST = state == OWN0 ? M0_HBURST : state == OWN1 ? M1_HBURST : '0;
  assign HTRANS = state == OWN0 ? M0_HTRANS : state == OWN1 ? M1_HTRANS : '0;
  assign HWRITE = state == OWN0 ? M0_HWRITE : state == OWN1 && M1_HWRITE;
  assign HWDATA = dp[0] ? M0_HWDATA : dp[1] ? M1_HWDATA : '0;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;
  assign M0_HRESP  = dp[0] & HRESP;
  assign M1_HRESP  = dp[1] & HRESP;
  // Masters held off while waiting; forced ready during reset regardless of requests.
  assign M0_HREADY = !HRESET_N ? 1'b1 : (GRANT[0] || dp[0]) ? HREADY : !m0_req;
  assign M1_HREADY = !HRESET_N ? 1'b1 : (GRANT[1] || dp[1]) ? HREADY : !m1_req;
  // An ERROR response freezes burst tracking and arbitration until the owner goes IDLE.
  assign acc        = HREADY & ~HRESP;
  assign nonseq_acc = acc && HTRANS == 2'd2;
  assign seq_acc    = acc && HTRANS == 2'd3;
  assign idle_acc   = acc && HTRANS == 2'd0;
  assign len        = HBURST == 3'd1 ? 5'd0 : HBURST == 3'd0 ? 5'd1 : 5'd2 << HBURST[2:1];
  assign fixed_end  = (nonseq_acc && HBURST == 3'd0) || (seq_acc && !incr && beat == 5'd1);
  assign burst_end  = fixed_end || (idle_acc && incr);
  assign rearb      = state == NONE || fixed_end || idle_acc;
  assign m0_cnt_nx  = m0_cnt + CW'(state == OWN0 && burst_end && m1_req && m0_cnt < CW'(MAX_M0_BURSTS));
  always_comb begin
    pick = (!m0_req && !m1_req) ? NONE
         : (m1_req && (!m0_req || m0_cnt_nx >= CW'(MAX_M0_BURSTS))) ? OWN1 : OWN0;
    state_nx = rearb ? pick : state;
  end
  always_ff @(posedge HCLK or negedge HRESET_N) begin
    if (!HRESET_N) begin
      state  <= NONE;
      dp     <= 2'b00;
      beat   <= '0;
      incr   <= 1'b0;
      m0_cnt <= '0;
    end else begin
      state  <= state_nx;
      m0_cnt <= (state_nx == OWN1 || !m1_req) ? '0 : m0_cnt_nx;
      if (HREADY) dp <= HTRANS[1] ? GRANT : 2'b00;
      if (nonseq_acc) begin
        beat <= HBURST == 3'd1 ? 5'd0 : len - 5'd1;
        incr <= HBURST == 3'd1;
      end else if (seq_acc && !incr && beat != 5'd0) begin
        beat <= beat - 5'd1;
      end else if (idle_acc) begin
        beat <= '0;
        incr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed vector table plus hand sequences for fairness, wait states and reset.
module tb_ahb_master_arbiter;
  localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2, S = 2'd3;
  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'hA0A0_5555, D1 = 32'hB1B1_AAAA, RD = 32'h1234_5678;
  logic HCLK = 1'b0, HRESET_N;
  logic [31:0] M0_HADDR = A0, M1_HADDR = A1, M0_HWDATA = D0, M1_HWDATA = D1, HRDATA = RD;
  logic [2:0]  M0_HBURST, M1_HBURST;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE = 1'b0, M1_HWRITE = 1'b1;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] M0_HRDATA, M1_HRDATA, HADDR, HWDATA;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS, GRANT;
  logic        HWRITE, HREADY, HRESP;
  int total = 0, bad = 0;

  ahb_master_arbiter #(.MAX_M0_BURSTS(4)) dut (
    .HCLK(HCLK), .HRESET_N(HRESET_N),
    .M0_HADDR(M0_HADDR), .M0_HBURST(M0_HBURST), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HBURST(M1_HBURST), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
    .HADDR(HADDR), .HBURST(HBURST), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .GRANT(GRANT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0] t0; logic [2:0] b0; logic [1:0] t1; logic [2:0] b1; logic rdy, resp;
    logic [1:0] grant, htrans; logic r0, r1, e0, e1; logic [1:0] wd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t0, input logic [2:0] b0, input logic [1:0] t1,
                       input logic [2:0] b1, input logic rdy, input logic resp);
    M0_HTRANS = t0; M0_HBURST = b0; M1_HTRANS = t1; M1_HBURST = b1; HREADY = rdy; HRESP = resp;
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic add(input logic [1:0] t0, input logic [2:0] b0, input logic [1:0] t1, input logic [2:0] b1,
                     input logic rdy, input logic resp, input logic [1:0] g, input logic [1:0] ht,
                     input logic r0, input logic r1, input logic e0, input logic e1, input logic [1:0] wd);
    vec_t x;
    x.t0 = t0; x.b0 = b0; x.t1 = t1; x.b1 = b1; x.rdy = rdy; x.resp = resp;
    x.grant = g; x.htrans = ht; x.r0 = r0; x.r1 = r1; x.e0 = e0; x.e1 = e1; x.wd = wd;
    tbl.push_back(x);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, GRANT, 2'b00);
    chk({tag, "_htrans"}, HTRANS, I);
    chk({tag, "_haddr"}, HADDR, 0);
    chk({tag, "_hwdata"}, HWDATA, 0);
    chk({tag, "_m0_hready"}, M0_HREADY, 1);
    chk({tag, "_m1_hready"}, M1_HREADY, 1);
    chk({tag, "_m0_hresp"}, M0_HRESP, 0);
    chk({tag, "_m1_hresp"}, M1_HRESP, 0);
  endtask

  initial begin
    // M0 INCR8 alone
    add(N,5,I,0,1,0, 2'b00,I,0,1,0,0,0);
    add(N,5,I,0,1,0, 2'b01,N,1,1,0,0,0);
    for (int i = 0; i < 7; i++) add(S,5,I,0,1,0, 2'b01,S,1,1,0,0,1);
    add(I,0,I,0,1,0, 2'b01,I,1,1,0,0,1);
    add(I,0,I,0,1,0, 2'b00,I,1,1,0,0,0);
    // simultaneous requests, M0 INCR4 then M1 INCR4
    add(N,3,N,3,1,0, 2'b00,I,0,0,0,0,0);
    add(N,3,N,3,1,0, 2'b01,N,1,0,0,0,0);
    for (int i = 0; i < 3; i++) add(S,3,N,3,1,0, 2'b01,S,1,0,0,0,1);
    add(I,0,N,3,1,0, 2'b01,I,1,0,0,0,1);
    add(I,0,N,3,1,0, 2'b10,N,1,1,0,0,0);
    for (int i = 0; i < 3; i++) add(I,0,S,3,1,0, 2'b10,S,1,1,0,0,2);
    add(I,0,I,0,1,0, 2'b10,I,1,1,0,0,2);
    add(I,0,I,0,1,0, 2'b00,I,1,1,0,0,0);
    // M0 undefined-length INCR with BUSY beats, M1 waiting
    add(N,1,I,0,1,0, 2'b00,I,0,1,0,0,0);
    add(N,1,N,0,1,0, 2'b01,N,1,0,0,0,0);
    add(B,1,N,0,1,0, 2'b01,B,1,0,0,0,1);
    add(S,1,N,0,1,0, 2'b01,S,1,0,0,0,0);
    add(B,1,N,0,1,0, 2'b01,B,1,0,0,0,1);
    add(B,1,N,0,1,0, 2'b01,B,1,0,0,0,0);
    add(S,1,N,0,1,0, 2'b01,S,1,0,0,0,0);
    add(S,1,N,0,1,0, 2'b01,S,1,0,0,0,1);
    add(I,0,N,0,1,0, 2'b01,I,1,0,0,0,1);
    add(I,0,N,0,1,0, 2'b10,N,1,1,0,0,0);
    add(I,0,I,0,1,0, 2'b10,I,1,1,0,0,2);
    add(I,0,I,0,1,0, 2'b00,I,1,1,0,0,0);
    // ERROR mid-burst: ownership held through both ERROR cycles
    add(N,3,N,0,1,0, 2'b00,I,0,0,0,0,0);
    add(N,3,N,0,1,0, 2'b01,N,1,0,0,0,0);
    add(S,3,N,0,0,1, 2'b01,S,0,0,1,0,1);
    add(I,0,N,0,1,1, 2'b01,I,1,0,1,0,1);
    add(I,0,N,0,1,0, 2'b01,I,1,0,0,0,0);
    add(I,0,N,0,1,0, 2'b10,N,1,1,0,0,0);
    add(I,0,I,0,1,0, 2'b10,I,1,1,0,0,2);
    add(I,0,I,0,1,0, 2'b00,I,1,1,0,0,0);

    HRESET_N = 1'b1;
    drive(N,5,N,0,1,1);
    #1 HRESET_N = 1'b0;
    #1 chk_reset_outputs("por");
    chk("por_m0_hrdata", M0_HRDATA, RD);
    chk("por_m1_hrdata", M1_HRDATA, RD);
    drive(I,0,I,0,1,0);
    tick; tick;
    HRESET_N = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].t0, tbl[i].b0, tbl[i].t1, tbl[i].b1, tbl[i].rdy, tbl[i].resp);
      #2;
      chk($sformatf("v%0d_grant", i), GRANT, tbl[i].grant);
      chk($sformatf("v%0d_htrans", i), HTRANS, tbl[i].htrans);
      chk($sformatf("v%0d_haddr", i), HADDR, tbl[i].grant == 2'b01 ? A0 : tbl[i].grant == 2'b10 ? A1 : 32'h0);
      chk($sformatf("v%0d_m0_hready", i), M0_HREADY, tbl[i].r0);
      chk($sformatf("v%0d_m1_hready", i), M1_HREADY, tbl[i].r1);
      chk($sformatf("v%0d_m0_hresp", i), M0_HRESP, tbl[i].e0);
      chk($sformatf("v%0d_m1_hresp", i), M1_HRESP, tbl[i].e1);
      chk($sformatf("v%0d_hwdata", i), HWDATA, tbl[i].wd == 2'd1 ? D0 : tbl[i].wd == 2'd2 ? D1 : 32'h0);
      tick;
    end

    // four back-to-back M0 INCR16 with M1 waiting; last burst carries two BUSY beats
    drive(N,7,N,0,1,0);
    #2 chk("fair_start_grant", GRANT, 2'b00);
    tick;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < (k == 3 ? 18 : 16); j++) begin
        drive(j == 0 ? N : (k == 3 && (j == 9 || j == 10)) ? B : S, 7, N, 0, 1, 0);
        #2 chk($sformatf("fair_b%0d_j%0d_grant", k, j), GRANT, 2'b01);
        if (j == 5) chk($sformatf("fair_b%0d_m1_hready", k), M1_HREADY, 0);
        tick;
      end
    drive(N,7,N,0,1,0);
    #2 chk("fair_m1_grant", GRANT, 2'b10);
    chk("fair_m1_htrans", HTRANS, N);
    chk("fair_m1_haddr", HADDR, A1);
    tick;
    drive(N,7,I,0,1,0);
    #2 chk("fair_m0_regain", GRANT, 2'b01);
    tick;
    drive(I,0,I,0,1,0);
    tick;
    #2 chk("fair_end_none", GRANT, 2'b00);
    tick;

    // M1 INCR4 write, 3 wait states on last data beat, M0 NONSEQ pipelined behind it
    drive(I,0,N,3,1,0);
    #2 chk("ws_req_grant", GRANT, 2'b00);
    tick;
    #2 chk("ws_m1_grant", GRANT, 2'b10);
    chk("ws_m1_hwrite", HWRITE, 1);
    tick;
    drive(I,0,S,3,1,0); tick; tick;
    drive(N,0,S,3,1,0);
    #2 chk("ws_last_grant", GRANT, 2'b10);
    chk("ws_m0_wait", M0_HREADY, 0);
    tick;
    for (int w = 0; w < 4; w++) begin
      drive(N,0,I,0,w == 3,0);
      #2 chk($sformatf("ws%0d_grant", w), GRANT, 2'b01);
      chk($sformatf("ws%0d_htrans", w), HTRANS, N);
      chk($sformatf("ws%0d_haddr", w), HADDR, A0);
      chk($sformatf("ws%0d_hwrite", w), HWRITE, 0);
      chk($sformatf("ws%0d_hwdata", w), HWDATA, D1);
      chk($sformatf("ws%0d_m1_hready", w), M1_HREADY, w == 3);
      chk($sformatf("ws%0d_m0_hready", w), M0_HREADY, w == 3);
      tick;
    end
    drive(I,0,I,0,1,0);
    #2 chk("ws_m0_hwdata", HWDATA, D0);
    chk("ws_m0_grant", GRANT, 2'b01);
    tick;
    #2 chk("ws_end_none", GRANT, 2'b00);
    tick;

    // reset asserted during beat 3 of an M0 INCR8
    drive(N,5,I,0,1,0); tick;
    tick;
    drive(S,5,I,0,1,0); tick;
    drive(S,5,N,0,1,1);
    #1 chk("rst_pre_grant", GRANT, 2'b01);
    chk("rst_pre_hresp", M0_HRESP, 1);
    HRESET_N = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    tick; tick;
    chk_reset_outputs("rst_hold");
    drive(N,5,I,0,1,0);
    HRESET_N = 1'b1;
    #2 chk("rst_rel_grant", GRANT, 2'b00);
    chk("rst_rel_m0_hready", M0_HREADY, 0);
    tick;
    #2 chk("rst_regrant", GRANT, 2'b01);
    chk("rst_regrant_htrans", HTRANS, N);
    tick;
    drive(I,0,I,0,1,0);
    tick;
    #2 chk("rst_end_none", GRANT, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter MAX_M0_BURSTS, default 4: consecutive M0 bursts allowed while M1 waits before M1 is forced a grant.
REQ-002 SHALL have port HCLK  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port HRESET_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports M0_HADDR/M1_HADDR  input  32  master address (M0 = TFT DMA, M1 = secondary master).
REQ-005 SHALL have ports M0_HBURST/M1_HBURST  input  3  AHB_PKG::burst_t.
REQ-006 SHALL have ports M0_HTRANS/M1_HTRANS  input  2  AHB_PKG::trans_t (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-007 SHALL have ports M0_HWRITE/M1_HWRITE  input  1, and M0_HWDATA/M1_HWDATA  input  32.
REQ-008 SHALL have ports M0_HREADY/M1_HREADY  output  1, and M0_HRESP/M1_HRESP  output  1, per-master response.
REQ-009 SHALL have ports M0_HRDATA/M1_HRDATA  output  32  read data, both driven from slave HRDATA.
REQ-010 SHALL have ports HADDR  output  32, HBURST  output  3, HTRANS  output  2, HWRITE  output  1, HWDATA  output  32: slave side.
REQ-011 SHALL have ports HRDATA  input  32, HREADY  input  1, HRESP  input  1: slave response.
REQ-012 SHALL have port GRANT  output  2  one-hot address-phase owner ({M1,M0}); 2'b00 = no owner.

Function
REQ-013 SHALL implement states NONE, OWN0, OWN1; the owner's address-phase signals SHALL drive HADDR/HBURST/HTRANS/HWRITE; NONE drives HTRANS=IDLE, HADDR=0.
REQ-014 SHALL treat a master as requesting when its HTRANS != IDLE.
REQ-015 SHALL, in NONE, grant M0 if requesting, else M1 if requesting, else stay in NONE; the transition takes effect the next cycle, so the first NONSEQ reaches the slave 1 cycle after the request.
REQ-016 SHALL load a 5-bit beat counter on an accepted NONSEQ (owner HTRANS=NONSEQ and HREADY=1): SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=undefined-length.
REQ-017 SHALL decrement the counter on each accepted transfer; BUSY SHALL be passed through without decrementing.
REQ-018 SHALL declare burst end on the accepted beat that brings the counter to 0, or, for INCR, on an owner IDLE with HREADY=1.
REQ-019 SHALL re-arbitrate only at burst end or when the owner presents IDLE with HREADY=1, never mid-burst.
REQ-020 SHALL apply, at re-arbitration: M0 wins over M1, except when M1 is requesting and the M0 burst count has reached MAX_M0_BURSTS, in which case M1 wins; M1 SHALL own for exactly one burst when M0 is requesting.
REQ-021 SHALL count consecutive M0 bursts ended while M1 requests, and clear the count when M1 is granted or M1 stops requesting.
REQ-022 SHALL go to NONE when neither master requests at re-arbitration, and stay with the current owner when only that owner requests.
REQ-023 SHALL register a data-phase owner DP (none/M0/M1) from the address owner and HTRANS∈{NONSEQ,SEQ} whenever HREADY=1.
REQ-024 SHALL drive HWDATA from DP's master (0 when DP=none).
REQ-025 SHALL drive Mx_HREADY as follows: slave HREADY if x is address or data-phase owner; 0 if x is requesting but not owner; 1 otherwise.
REQ-026 SHALL drive Mx_HRESP = HRESP when x is DP, else OKAY (0).
REQ-027 SHALL, when a handover occurs with an outstanding data phase, complete the old DP on HREADY while the new owner's NONSEQ sits in the same cycle's address phase (normal AHB pipelining, no bubble).
REQ-028 SHALL handle ERROR response (HRESP=1) as follows: the owner keeps ownership until it issues IDLE; no ownership change occurs during the two-cycle ERROR.

Reset
REQ-029 SHALL, while HRESET_N=0 (async assert, sync-released by the source): state NONE, GRANT=00, DP=none, counters 0, HTRANS=IDLE, HADDR/HWDATA=0, Mx_HREADY=1, Mx_HRESP=0.
REQ-030 SHALL abandon any burst in progress on reset mid-burst; first grant after release follows REQ-015.

Verification
REQ-031 SHALL cover: M0 INCR8 read alone, HREADY=1 -> GRANT=01 one cycle after request, 8 beats, NONE after IDLE.
REQ-032 SHALL cover: M0 and M1 both request NONSEQ in the same cycle -> M0 granted, M1_HREADY=0 until M0 INCR4 burst end, then GRANT=10.
REQ-033 SHALL cover: M0 issues back-to-back INCR16 with M1 waiting, MAX_M0_BURSTS=4 -> M1 granted after the 4th M0 burst, then M0 regains ownership.
REQ-034 SHALL cover: slave inserts 3 wait states on the last beat of an M1 INCR4 write -> M1_HWDATA is held on HWDATA until HREADY, and M0 NONSEQ is presented in the same cycle.
REQ-035 SHALL cover: M0 undefined-length INCR with BUSY beats -> no re-arbitration until M0 IDLE; BUSY does not decrement the counter.
REQ-036 SHALL cover: HRESET_N low during beat 3 of an INCR8 -> all outputs at the REQ-029 values immediately, and a clean NONE→OWN grant after release.
